uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Standalone 8N1 UART receiver with a small elastic buffer. It feeds the CPU-side serial input that the SoC top currently ties high, and complements the existing UART transmit path.
- Synchronises the asynchronous rxd pin and samples each bit at mid-bit using a programmable clocks-per-bit divider.
- Rejects false starts and reports framing/overrun errors.
- Delivers bytes on a valid/ready stream.

Parameters:
DIV_W, 16, width of cfg_div
FIFO_DEPTH, 4, receive buffer entries; power of 2, minimum 2

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
cfg_div  input  DIV_W  clocks per bit; must be held stable while not idle; values <4 treated as 4
rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  head-of-FIFO byte
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
err_frame  output  1  one-cycle pulse: stop bit sampled low
err_overrun  output  1  one-cycle pulse: byte completed while FIFO full with no pop that cycle
err_parity  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
busy  output  1  receiver FSM not in IDLE

Behaviour:
- Reset: all FIFO pointers 0; rx_valid=0, rx_data=0, all err_* = 0, busy=0; both synchroniser flops = 1; FSM in IDLE; bit and divider counters 0.
- Synchroniser: 2 flops (rxd_s). Falling-edge detection compares rxd_s with its 1-cycle delayed copy.
- Effective divider D = max(cfg_div, 4); half-bit H = D>>1.
- FSM:
  - IDLE: on rxd_s falling edge, load counter and go to START.
  - START: after H cycles, sample. If rxd_s=1 (false start), return to IDLE with no error. Otherwise go to DATA with bit index 0.
  - DATA: every D cycles, sample rxd_s into the shift register, LSB first. After bit 7, go to STOP (or PARITY when the feature is enabled).
  - STOP: after D cycles, sample. If 1, push the byte and go to IDLE. If 0, pulse err_frame, discard the byte, and go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. A held-low line yields exactly one err_frame.
- Stop-bit sample cycle, measured from the pin falling edge: 2 + 9*D + H (±1). rx_valid rises on the next cycle when the FIFO was empty.
- FIFO:
  - Pop when rx_valid & rx_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - Push when full without a pop: byte dropped, err_overrun pulses, FIFO contents unchanged.
  - Pop when empty: ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide with natural wrap; full/empty are derived from the MSB compare.
- rx_data is the registered head entry and changes only on a push into an empty FIFO or on a pop. rx_data and rx_valid never glitch.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied, and nothing is reported. After reset, the line is only reacquired on a fresh falling edge.
- err_* pulses are mutually exclusive per frame and never last more than one cycle.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds parameter PARITY_ODD (default 0, i.e. even parity) and a PARITY state between DATA and STOP that samples one extra bit D cycles after bit 7. The stop sample moves to 2 + 10*D + H. On mismatch: err_parity pulses at the stop-sample cycle, the byte is discarded, and framing is still checked. If both parity and framing fail, only err_frame is reported.
- Undefined: 8N1 only; err_parity is constant 0.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), DATA_BITS=8, MIN_DIV=4.
- Sub-module uart_rx_fifo_mem: FIFO_DEPTH x 8 storage with pointers and full/empty flags.
- Top-level contents: synchroniser, FSM, counters and error logic.

Test Plan:
- cfg_div=16, rx_ready=1, send 0x55 then 0xA3 back-to-back: rx_data shows 0x55 then 0xA3, each as a one-cycle handshake; first rx_valid about 155 cycles after the first falling edge; no err_*.
- 3-cycle low glitch on rxd, cfg_div=16: no rx_valid and no err_*; the FSM returns to IDLE before cycle 12.
- Frame 0x00 with stop bit low, line held low for 40 bit-times, then 0x7E: exactly one err_frame, and only 0x7E is received.
- rx_ready=0, FIFO_DEPTH=4, send 5 bytes 0x01..0x05: one err_overrun after the 5th. Draining yields 0x01..0x04, then rx_valid=0.
- FIFO full, rx_ready pulsed on the exact cycle the 5th byte completes: no err_overrun; drain yields 0x02..0x05.
- resetn deasserted during bit 4 of 0xC3, released, then 0x3C sent: only 0x3C received; all outputs 0 while in reset. With UART_RX_PARITY_EN and even parity, 0x07 with parity bit 0 gives one err_parity pulse and no byte.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the uart_rx_fifo receiver: FSM state encoding and frame constants.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Received-byte valid/ready stream between the UART receiver (master) and its consumer (slave).
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO: FIFO_DEPTH x 8 storage with wrap-bit pointers and a registered head byte.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] head_o,
  output logic                 valid_o,
  output logic                 full_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic                 valid_q;
  logic                 empty, full, do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign do_push = push_i & (~full | do_pop);
  assign rd_nxt  = rd_q + 1'b1;

  always_comb begin
    wr_d   = do_push ? (wr_q + 1'b1) : wr_q;
    rd_d   = do_pop ? rd_nxt : rd_q;
    head_d = head_q;
    if (empty) begin
      if (do_push) head_d = wdata_i;
    end else if (do_pop) begin
      if (rd_nxt != wr_q)  head_d = mem_q[rd_nxt[AW-1:0]];
      else if (do_push)    head_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      valid_q <= (wr_d != rd_d);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign full_o  = full;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, false-start rejection, error pulses and a receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             rxd,
  uart_rx_fifo_if.master   rx,
  output logic             err_frame,
  output logic             err_overrun,
  output logic             err_parity,
  output logic             busy
);

  localparam int                BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0]     BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0]  ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(MIN_DIV);

  logic                 sync1_q, rxd_s_q, rxd_prev_q, armed_q;
  logic [1:0]           fill_q;
  logic                 fall;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_eff, half;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push, pop, fifo_full, fifo_valid;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 frame_d, err_frame_q, err_overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d, par_err_d, err_parity_q;
`endif

  assign div_eff = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
  assign half    = div_eff >> 1;

  // The synchroniser resets high, so the line is only armed once a real high
  // level has propagated; this stops a low line at reset release posing as a start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      rxd_s_q    <= sync1_q;
      rxd_prev_q <= rxd_s_q;
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_q | (fill_q[1] & rxd_s_q);
    end
  end

  assign fall = armed_q & rxd_prev_q & ~rxd_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    frame_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = half - ONE;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rxd_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = div_eff - ONE;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = div_eff - ONE;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          par_bad_d = ((^shift_q) ^ rxd_s_q) != PARITY_ODD;
          cnt_d     = div_eff - ONE;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rxd_s_q) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) par_err_d = 1'b1;
            else           push      = 1'b1;
`else
            push    = 1'b1;
`endif
          end else begin
            frame_d = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_BREAK: begin
        if (rxd_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      err_frame_q   <= frame_d;
      err_overrun_q <= push & fifo_full & ~pop;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_bad_q    <= 1'b0;
      err_parity_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      err_parity_q <= par_err_d;
    end
  end
  assign err_parity = err_parity_q;
`else
  assign err_parity = 1'b0;
`endif

  assign pop = fifo_valid & rx.rx_ready;

  uart_rx_fifo_mem #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign rx.rx_data  = fifo_head;
  assign rx.rx_valid = fifo_valid;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written multi-cycle sequences.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic             rxd    = 1'b1;
  logic [DIV_W-1:0] cfg_div = 16'd16;
  logic             err_frame, err_overrun, err_parity, busy;

  uart_rx_fifo_if rxif ();

  uart_rx_fifo #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_div     (cfg_div),
    .rxd         (rxd),
    .rx          (rxif),
    .err_frame   (err_frame),
    .err_overrun (err_overrun),
    .err_parity  (err_parity),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_fall  = 0;
  logic [7:0] rx_q [$];
  int rise_q [$];
  int n_frame = 0, n_over = 0, n_par = 0, n_bad = 0, vld_cycles = 0;
  logic vld_prev = 1'b0, ef_prev = 1'b0, eo_prev = 1'b0, ep_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
  int par_force = -1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!resetn) begin
      vld_prev = 1'b0; ef_prev = 1'b0; eo_prev = 1'b0; ep_prev = 1'b0;
    end else begin
      if (rxif.rx_valid && rxif.rx_ready) rx_q.push_back(rxif.rx_data);
      if (rxif.rx_valid) vld_cycles++;
      if (rxif.rx_valid && !vld_prev) rise_q.push_back(cyc);
      if (err_frame)   n_frame++;
      if (err_overrun) n_over++;
      if (err_parity)  n_par++;
      if ((err_frame && ef_prev) || (err_overrun && eo_prev) || (err_parity && ep_prev)) n_bad++;
      if (int'(err_frame) + int'(err_overrun) + int'(err_parity) > 1) n_bad++;
      vld_prev = rxif.rx_valid; ef_prev = err_frame; eo_prev = err_overrun; ep_prev = err_parity;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    int d;
    d = (cfg_div < 16'd4) ? 4 : int'(cfg_div);
    tick();
    rxd = 1'b0;
    t_fall = cyc;
    repeat (d) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (d) tick();
    end
`ifdef UART_RX_PARITY_EN
    rxd = (par_force < 0) ? ^b : par_force[0];
    repeat (d) tick();
`endif
    rxd = stop;
    repeat (d * stop_bits) tick();
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         div;
    int         exp_bytes;
    int         exp_frame;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n0, f0, o0, e0, vc0, r0, t1, d;

    vecs[0] = '{8'h55, 1'b1, 16, 1, 0};
    vecs[1] = '{8'hA3, 1'b1, 16, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 4,  1, 0};
    vecs[3] = '{8'hFF, 1'b1, 4,  1, 0};
    vecs[4] = '{8'h81, 1'b1, 2,  1, 0};
    vecs[5] = '{8'h5A, 1'b1, 7,  1, 0};
    vecs[6] = '{8'h0F, 1'b0, 16, 0, 1};
    vecs[7] = '{8'hC6, 1'b1, 0,  1, 0};

    rxif.rx_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    check("reset_valid", rxif.rx_valid, 0);
    check("reset_data", rxif.rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_errs", {err_frame, err_overrun, err_parity}, 0);
    resetn = 1'b1;
    idle(10);

    // Table of single frames with ready held high
    rxif.rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cfg_div = DIV_W'(vecs[i].div);
      d = (vecs[i].div < 4) ? 4 : vecs[i].div;
      n0 = rx_q.size();
      f0 = n_frame;
      send_frame(vecs[i].data, vecs[i].stop, 1);
      idle(3 * d);
      check($sformatf("vec%0d_bytes", i), rx_q.size() - n0, vecs[i].exp_bytes);
      if (vecs[i].exp_bytes == 1) check($sformatf("vec%0d_data", i), rx_q[n0], vecs[i].data);
      check($sformatf("vec%0d_frame", i), n_frame - f0, vecs[i].exp_frame);
    end

    // Back-to-back 0x55, 0xA3 with latency of the first byte
    cfg_div = 16'd16;
    idle(20);
    n0 = rx_q.size(); vc0 = vld_cycles; r0 = rise_q.size();
    f0 = n_frame; o0 = n_over;
    send_frame(8'h55, 1'b1, 1);
    t1 = t_fall;
    send_frame(8'hA3, 1'b1, 1);
    idle(40);
    check("b2b_bytes", rx_q.size() - n0, 2);
    check("b2b_first", rx_q[n0], 8'h55);
    check("b2b_second", rx_q[n0 + 1], 8'hA3);
    check("b2b_valid_cycles", vld_cycles - vc0, 2);
    check("b2b_latency_ok", (rise_q[r0] - t1 >= 154) && (rise_q[r0] - t1 <= 156), 1);
    check("b2b_errs", (n_frame - f0) + (n_over - o0), 0);

    // Short low glitch must be rejected without an error
    n0 = rx_q.size(); f0 = n_frame; o0 = n_over;
    tick();
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (2) tick();
    check("glitch_busy_mid", busy, 1);
    repeat (7) tick();
    check("glitch_busy_end", busy, 0);
    idle(40);
    check("glitch_bytes", rx_q.size() - n0, 0);
    check("glitch_errs", (n_frame - f0) + (n_over - o0), 0);

    // Break: stop bit low and line held low for 40 bit-times, then 0x7E
    n0 = rx_q.size(); f0 = n_frame;
    send_frame(8'h00, 1'b0, 40);
    idle(32);
    send_frame(8'h7E, 1'b1, 1);
    idle(48);
    check("break_frame_errs", n_frame - f0, 1);
    check("break_bytes", rx_q.size() - n0, 1);
    check("break_data", rx_q[n0], 8'h7E);

    // Overrun: five bytes into a four-entry FIFO with no consumer
    rxif.rx_ready = 1'b0;
    n0 = rx_q.size(); o0 = n_over;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1);
    idle(48);
    check("ovr_count", n_over - o0, 1);
    check("ovr_full_valid", rxif.rx_valid, 1);
    rxif.rx_ready = 1'b1;
    idle(10);
    rxif.rx_ready = 1'b0;
    check("ovr_drain_bytes", rx_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovr_drain%0d", i), rx_q[n0 + i], 8'(i + 1));
    check("ovr_empty", rxif.rx_valid, 0);

    // Pop on the exact cycle the fifth byte completes into a full FIFO
    n0 = rx_q.size(); o0 = n_over;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1);
    idle(20);
    fork
      send_frame(8'h05, 1'b1, 1);
      begin
        tick();
        repeat (154) tick();
        rxif.rx_ready = 1'b1;
        tick();
        rxif.rx_ready = 1'b0;
      end
    join
    idle(40);
    check("pull_overrun", n_over - o0, 0);
    rxif.rx_ready = 1'b1;
    idle(10);
    check("pull_bytes", rx_q.size() - n0, 5);
    for (int i = 0; i < 5; i++) check($sformatf("pull_byte%0d", i), rx_q[n0 + i], 8'(i + 1));

    // Reset in the middle of 0xC3 while the FIFO holds an unread byte
    rxif.rx_ready = 1'b0;
    send_frame(8'h96, 1'b1, 1);
    idle(20);
    check("pre_reset_valid", rxif.rx_valid, 1);
    check("pre_reset_data", rxif.rx_data, 8'h96);
    n0 = rx_q.size();
    e0 = n_frame + n_over + n_par;
    fork
      send_frame(8'hC3, 1'b1, 1);
      begin
        tick();
        repeat (88) tick();
        resetn = 1'b0;
        #2;
        check("inrst_valid", rxif.rx_valid, 0);
        check("inrst_data", rxif.rx_data, 0);
        check("inrst_busy", busy, 0);
        check("inrst_errs", {err_frame, err_overrun, err_parity}, 0);
        repeat (3) tick();
        resetn = 1'b1;
      end
    join
    rxif.rx_ready = 1'b1;
    idle(32);
    send_frame(8'h3C, 1'b1, 1);
    idle(48);
    check("postrst_bytes", rx_q.size() - n0, 1);
    check("postrst_data", rx_q[n0], 8'h3C);
    check("postrst_errs", n_frame + n_over + n_par - e0, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1, so 0 is a mismatch
    n0 = rx_q.size(); f0 = n_frame; e0 = n_par;
    par_force = 0;
    send_frame(8'h07, 1'b1, 1);
    par_force = -1;
    idle(48);
    check("par_err", n_par - e0, 1);
    check("par_bytes", rx_q.size() - n0, 0);
    check("par_frame", n_frame - f0, 0);
`else
    check("par_never", n_par, 0);
`endif

    check("pulse_shape", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
